divrem_arbiter: RTL
===================

DIVREM_ARBITER -- requirements
Module: divrem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH_LOG, default 4, operand width exponent; WIDTH = 1 << WIDTH_LOG.
REQ-002 The block SHALL have parameter NREQ, default 2, number of requesters, legal range 2..8.
REQ-003 The block SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req  input  NREQ  per-requester level request; held high until the matching ack pulse.
REQ-006 The block SHALL have port num  input  NREQ*WIDTH  flattened dividends; slice i belongs to requester i.
REQ-007 The block SHALL have port den  input  NREQ*WIDTH  flattened divisors; slice i belongs to requester i.
REQ-008 The block SHALL have port ack  output  NREQ  one-hot, one-cycle pulse marking rem/error valid for the granted requester.
REQ-009 The block SHALL have port rem  output  WIDTH  remainder of the last completed operation; held until the next ack.
REQ-010 The block SHALL have port error  output  1  error flag of the last completed operation; held until the next ack.
REQ-011 The block SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-012 The block SHALL share one divrem instance among NREQ requesters, one operation in flight at a time.
REQ-013 The state machine SHALL have states IDLE, ISSUE, DLY, WAIT and RESP.
REQ-014 IDLE SHALL take the next state from req as follows: no req -> stay; any req -> round-robin pick, then latch num/den slices into operand registers and record the grant index.
REQ-015 Round-robin SHALL search from (last_grant+1) mod NREQ upward with wrap-around; last_grant updates only on a grant.
REQ-016 On a grant with latched den != 0 the next state SHALL be ISSUE; with den == 0 it SHALL be RESP with rem=0 and error=1, and div_go SHALL NOT be asserted.
REQ-017 ISSUE SHALL assert the registered divrem go for exactly one cycle, then go to DLY.
REQ-018 DLY SHALL be a one-cycle wait allowing divrem to register its inputs and clear ready, then go to WAIT.
REQ-019 WAIT SHALL hold while divrem ready=0 and error=0; on ready or error it SHALL capture rem and error into the output registers and go to RESP.
REQ-020 RESP SHALL pulse ack[grant] for one cycle, then go to IDLE; req SHALL NOT be sampled in RESP.
REQ-021 A requester that keeps req high after its ack SHALL be treated as a new request at the next IDLE and SHALL rotate fairly with the other requesters.
REQ-022 Operands SHALL be sampled only at grant; later changes to num/den SHALL NOT affect the operation in flight.
REQ-023 Fixed overhead SHALL be IDLE-grant to ack = 4 cycles plus the divrem compute time; the den=0 path SHALL give ack 2 cycles after the grant edge.
REQ-024 ack SHALL be zero or one-hot at all times.
REQ-025 An unreachable state encoding SHALL drive X on next state in simulation and recover to IDLE in synthesis.

Reset
REQ-026 On rst the block SHALL set state=IDLE, ack=0, busy=0, rem=0, error=0, last_grant=NREQ-1 (requester 0 wins first) and divrem go=0.
REQ-027 rst mid-operation (ISSUE/DLY/WAIT/RESP) SHALL abort the operation: no ack is ever issued for it, and the same rst resets divrem.
REQ-028 req asserted during rst SHALL be ignored until the first cycle after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the state encodings (3-bit localparams) and the WIDTH/NREQ-derived constants (index width = clog2(NREQ)).
REQ-030 The block SHALL contain one sub-module: the existing divrem, parameterised with WIDTH_LOG; no other hierarchy.

Verification (WIDTH_LOG=4, NREQ=2)
REQ-031 Single op: req[0] with 35/6 -> exactly one div_go, ack[0] pulse once, rem=5, error=0.
REQ-032 Collision after reset: req[0] with 35/6 and req[1] with 49/7 asserted in the same cycle -> ack[0] (rem=5) first, then ack[1] (rem=0).
REQ-033 Fairness: both requesters re-requesting continuously for 10 operations -> grant order 0,1,0,1,..., with 5 acks each.
REQ-034 Divide by zero: req[1] with 9/0 -> ack[1] 2 cycles after grant, error=1, rem=0, no div_go pulse.
REQ-035 Reset in WAIT: rst for 1 cycle -> next cycle busy=0 and ack=0, no stale ack ever appears; a subsequent req[0] with 3/7 gives rem=3.
REQ-036 Edge operands: 65535/1 -> rem=0; 3/7 -> rem=3; num changed after grant -> result still reflects the latched operands.

Source files
------------

// File: rtl/divrem_arbiter_pkg.sv
// Shared encodings and size helpers for the divrem arbiter slice.
package divrem_arbiter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_DLY   = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  localparam int DEF_WIDTH_LOG = 4;
  localparam int DEF_NREQ      = 2;

  // Operand width from its exponent.
  function automatic int op_width(input int wlog);
    return 1 << wlog;
  endfunction

  // Width of a requester index; never below one bit.
  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/divrem_arbiter_divrem.sv
// Iterative restoring divider returning the remainder; one quotient bit per cycle.
// ready is high while idle, drops on the edge that samples go, and rises again
// when the result is valid. A zero divisor reports error immediately.
module divrem
  import divrem_arbiter_pkg::*;
#(
  parameter int WIDTH_LOG = DEF_WIDTH_LOG
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               go,
  input  logic [op_width(WIDTH_LOG)-1:0]     num,
  input  logic [op_width(WIDTH_LOG)-1:0]     den,
  output logic                               ready,
  output logic                               error,
  output logic [op_width(WIDTH_LOG)-1:0]     rem
);

  localparam int WIDTH = op_width(WIDTH_LOG);

  logic [WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   den_reg;
  logic [WIDTH_LOG:0] count_reg;
  logic               busy_reg;
  logic               ready_reg;
  logic               error_reg;
  logic [WIDTH:0]     shift_next;
  logic [WIDTH:0]     diff_next;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    shift_next = {acc_reg, quo_reg[WIDTH-1]};
    diff_next  = shift_next - {1'b0, den_reg};
  end

  // Operand capture on go, then one restoring step per cycle until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      quo_reg   <= '0;
      den_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b1;
      error_reg <= 1'b0;
    end else if (go) begin
      acc_reg   <= '0;
      quo_reg   <= num;
      den_reg   <= den;
      count_reg <= (WIDTH_LOG + 1)'(WIDTH);
      if (den == '0) begin
        busy_reg  <= 1'b0;
        ready_reg <= 1'b1;
        error_reg <= 1'b1;
      end else begin
        busy_reg  <= 1'b1;
        ready_reg <= 1'b0;
        error_reg <= 1'b0;
      end
    end else if (busy_reg) begin
      if (shift_next >= {1'b0, den_reg}) begin
        acc_reg <= diff_next[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_reg <= shift_next[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
      end
      count_reg <= count_reg - 1'b1;
      if (count_reg == (WIDTH_LOG + 1)'(1)) begin
        busy_reg  <= 1'b0;
        ready_reg <= 1'b1;
      end
    end
  end

  assign ready = ready_reg;
  assign error = error_reg;
  assign rem   = acc_reg;

endmodule

// File: rtl/divrem_arbiter.sv
// Round-robin arbiter sharing a single divrem among NREQ requesters.
// One operation in flight; operands are frozen at grant, results are held
// until the next ack.
module divrem_arbiter
  import divrem_arbiter_pkg::*;
#(
  parameter int WIDTH_LOG = DEF_WIDTH_LOG,
  parameter int NREQ      = DEF_NREQ
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ*op_width(WIDTH_LOG)-1:0]  num,
  input  logic [NREQ*op_width(WIDTH_LOG)-1:0]  den,
  output logic [NREQ-1:0]                      ack,
  output logic [op_width(WIDTH_LOG)-1:0]       rem,
  output logic                                 error,
  output logic                                 busy
);

  localparam int WIDTH = op_width(WIDTH_LOG);
  localparam int IDXW  = idx_width(NREQ);

  state_t            state_reg;
  logic [IDXW-1:0]   last_grant_reg;
  logic [IDXW-1:0]   grant_reg;
  logic [WIDTH-1:0]  num_reg;
  logic [WIDTH-1:0]  den_reg;
  logic              div_go;
  logic [NREQ-1:0]   ack_reg;
  logic [WIDTH-1:0]  rem_reg;
  logic              error_reg;
  logic              busy_reg;

  logic              found;
  logic [IDXW-1:0]   pick;
  logic [IDXW-1:0]   cand_idx;
  int                cand;
  logic [WIDTH-1:0]  num_sel;
  logic [WIDTH-1:0]  den_sel;

  logic              div_ready;
  logic              div_error;
  logic [WIDTH-1:0]  div_rem;

  // Round-robin search starting one past the last grant, wrapping around.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_grant_reg) + k) % NREQ;
      cand_idx = IDXW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
    num_sel = num[pick*WIDTH +: WIDTH];
    den_sel = den[pick*WIDTH +: WIDTH];
  end

  // Arbitration FSM; every output is registered so ack and go are glitch-free pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= IDXW'(NREQ - 1);
      grant_reg      <= '0;
      num_reg        <= '0;
      den_reg        <= '0;
      div_go         <= 1'b0;
      ack_reg        <= '0;
      rem_reg        <= '0;
      error_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      div_go  <= 1'b0;
      ack_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (found) begin
            grant_reg      <= pick;
            last_grant_reg <= pick;
            num_reg        <= num_sel;
            den_reg        <= den_sel;
            busy_reg       <= 1'b1;
            if (den_sel != '0) begin
              div_go    <= 1'b1;
              state_reg <= ST_ISSUE;
            end else begin
              // Divide by zero never reaches the divider.
              rem_reg   <= '0;
              error_reg <= 1'b1;
              state_reg <= ST_RESP;
            end
          end
        end
        ST_ISSUE: state_reg <= ST_DLY;
        // Give the divider a cycle to register operands and drop ready.
        ST_DLY:   state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (div_ready || div_error) begin
            rem_reg   <= div_rem;
            error_reg <= div_error;
            state_reg <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_reg[grant_reg] <= 1'b1;
          busy_reg           <= 1'b0;
          state_reg          <= ST_IDLE;
        end
        default: begin
`ifndef SYNTHESIS
          state_reg <= 'x;
`else
          state_reg <= ST_IDLE;
`endif
        end
      endcase
    end
  end

  divrem #(
    .WIDTH_LOG (WIDTH_LOG)
  ) u_divrem (
    .clk   (clk),
    .rst   (rst),
    .go    (div_go),
    .num   (num_reg),
    .den   (den_reg),
    .ready (div_ready),
    .error (div_error),
    .rem   (div_rem)
  );

  assign ack   = ack_reg;
  assign rem   = rem_reg;
  assign error = error_reg;
  assign busy  = busy_reg;

endmodule
